// File: rtl/spi_feature_rx.sv
// SPI mode-0 slave feeding received feature bytes into a small FWFT FIFO, with frame counting.
// Optional status readback on MISO is enabled by defining SPI_MISO_STATUS_EN.
module spi_feature_rx #(
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_SIZE = 1024
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_spi_sclk,
  input  logic                          i_spi_cs_n,
  input  logic                          i_spi_mosi,
  output logic                          o_spi_miso,
  input  logic                          i_rd_en,
  output logic                          o_feature_valid,
  output logic [7:0]                    o_feature,
  output logic                          o_frame_done,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int FCW = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  logic [2:0]     sclk_sync_q, sclk_sync_d;
  logic [2:0]     cs_n_sync_q, cs_n_sync_d;
  logic [1:0]     mosi_sync_q, mosi_sync_d;
  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           push_q, push_d;
  logic [7:0]     push_data_q, push_data_d;
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [7:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           overflow_q, overflow_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           frame_done_q, frame_done_d;

  logic sclk_rise, cs_fall, cs_rise, mosi_s;
  logic pop, full, wr;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], i_spi_sclk};
    cs_n_sync_d = {cs_n_sync_q[1:0], i_spi_cs_n};
    mosi_sync_d = {mosi_sync_q[0], i_spi_mosi};
    sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
    cs_fall     = ~cs_n_sync_q[1] & cs_n_sync_q[2];
    cs_rise     = cs_n_sync_q[1] & ~cs_n_sync_q[2];
    mosi_s      = mosi_sync_q[1];
  end

  // Receive FSM; the completed byte is staged one cycle before it reaches the FIFO.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
        end else if (sclk_rise) begin
          shreg_d = {shreg_q[6:0], mosi_s};
          if (bit_cnt_q == 3'd7) begin
            push_d      = 1'b1;
            push_data_d = {shreg_q[6:0], mosi_s};
            bit_cnt_d   = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop          = i_rd_en & (level_q != '0);
    full         = (level_q == LW'(FIFO_DEPTH));
    wr           = push_q & (~full | pop);
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    overflow_d   = overflow_q | (push_q & full & ~pop);
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    if (wr) begin
      mem_d[wr_ptr_q] = push_data_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // Dropped bytes still advance the frame counter to keep frame alignment.
    if (push_q) begin
      if (frame_cnt_q == FCW'(FRAME_SIZE - 1)) begin
        frame_cnt_d  = '0;
        frame_done_d = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + FCW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync_q  <= '0;
      cs_n_sync_q  <= '1;
      mosi_sync_q  <= '0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      cs_n_sync_q  <= cs_n_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_feature_valid = (level_q != '0);
  assign o_feature       = mem_q[rd_ptr_q];
  assign o_frame_done    = frame_done_q;
  assign o_overflow      = overflow_q;
  assign o_fifo_level    = level_q;

`ifdef SPI_MISO_STATUS_EN
  logic       sclk_fall, cs_active;
  logic [3:0] lvl_sat;
  logic [7:0] status;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       miso_q, miso_d;
  logic       fd_seen_q, fd_seen_d;

  // Status MSB goes out at CS fall; zero fill makes MISO read 0 after the 8th bit.
  always_comb begin
    sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    cs_active = ~cs_n_sync_q[1];
    lvl_sat   = (32'(level_q) > 32'd15) ? 4'hF : 4'(level_q);
    status    = {overflow_q, fd_seen_q, 2'b00, lvl_sat};
    tx_sh_d   = tx_sh_q;
    miso_d    = miso_q;
    fd_seen_d = fd_seen_q;
    if (cs_fall) begin
      miso_d    = status[7];
      tx_sh_d   = {status[6:0], 1'b0};
      fd_seen_d = 1'b0;
    end else if (!cs_active) begin
      miso_d  = 1'b0;
      tx_sh_d = '0;
    end else if (sclk_fall) begin
      miso_d  = tx_sh_q[7];
      tx_sh_d = {tx_sh_q[6:0], 1'b0};
    end
    if (frame_done_q) fd_seen_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_sh_q   <= '0;
      miso_q    <= 1'b0;
      fd_seen_q <= 1'b0;
    end else begin
      tx_sh_q   <= tx_sh_d;
      miso_q    <= miso_d;
      fd_seen_q <= fd_seen_d;
    end
  end

  assign o_spi_miso = miso_q;
`else
  assign o_spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_feature_rx.sv
// Directed bench for spi_feature_rx (FIFO_DEPTH=16, FRAME_SIZE=4); honours SPI_MISO_STATUS_EN.
module tb_spi_feature_rx;
  logic       clk = 1'b0;
  logic       rst_n, sclk, cs_n, mosi, rd_en;
  logic       miso, valid, fdone, ovf;
  logic [7:0] feat;
  logic [4:0] lvl;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  int long_cnt = 0;
  logic fd_prev = 1'b0;

  spi_feature_rx #(.FIFO_DEPTH(16), .FRAME_SIZE(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_spi_sclk(sclk), .i_spi_cs_n(cs_n),
    .i_spi_mosi(mosi), .o_spi_miso(miso), .i_rd_en(rd_en),
    .o_feature_valid(valid), .o_feature(feat), .o_frame_done(fdone),
    .o_overflow(ovf), .o_fifo_level(lvl)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fdone) begin
      fd_count++;
      if (fd_prev) long_cnt++;
    end
    fd_prev = fdone;
  end

  typedef struct {
    logic [7:0]  tx;
    int unsigned pops;
    logic        exp_valid;
    logic [7:0]  exp_head;
    logic [4:0]  exp_level;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    tick(4);
    m = miso;
    sclk = 1'b1;
    tick(4);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    logic m;
    for (int i = 7; i >= 0; i--) spi_bit(d[i], m);
  endtask

  task automatic frame_byte(input logic [7:0] d);
    cs_n = 1'b0;
    tick(4);
    send_byte(d);
    tick(4);
    cs_n = 1'b1;
    tick(8);
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; rd_en = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] exp_st;
    logic       m;
    int         found;
    int         base;

    tbl[0] = '{8'h11, 0, 1'b1, 8'h11, 5'd1};
    tbl[1] = '{8'h22, 0, 1'b1, 8'h11, 5'd2};
    tbl[2] = '{8'h33, 1, 1'b1, 8'h22, 5'd2};
    tbl[3] = '{8'h44, 2, 1'b1, 8'h44, 5'd1};
    tbl[4] = '{8'h55, 1, 1'b1, 8'h55, 5'd1};
    tbl[5] = '{8'h66, 2, 1'b0, 8'h00, 5'd0};
    tbl[6] = '{8'h77, 3, 1'b0, 8'h00, 5'd0};
    tbl[7] = '{8'h88, 0, 1'b1, 8'h88, 5'd1};

`ifdef SPI_MISO_STATUS_EN
    exp_st = 8'h83;
`else
    exp_st = 8'h00;
`endif

    rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; rd_en = 1'b0;
    tick(3);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_level", 32'(lvl), 32'd0);
    chk("rst_overflow", 32'(ovf), 32'd0);
    chk("rst_frame_done", 32'(fdone), 32'd0);
    chk("rst_miso", 32'(miso), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Single byte with latency bound measured from the pin-level 8th rise
    d = 8'hA5;
    cs_n = 1'b0;
    tick(4);
    for (int i = 7; i >= 1; i--) spi_bit(d[i], m);
    mosi = d[0];
    tick(4);
    sclk = 1'b1;
    found = 0;
    for (int c = 1; c <= 5 && found == 0; c++) begin
      tick(1);
      if (valid) found = 1;
    end
    chk("t1_valid_within_5", 32'(found), 32'd1);
    tick(3);
    sclk = 1'b0;
    tick(4);
    cs_n = 1'b1;
    tick(8);
    chk("t1_head", 32'(feat), 32'hA5);
    chk("t1_level", 32'(lvl), 32'd1);

    // Partial byte discarded on CS rise
    do_reset();
    cs_n = 1'b0;
    tick(4);
    d = 8'b10110000;
    for (int i = 7; i >= 3; i--) spi_bit(d[i], m);
    tick(4);
    cs_n = 1'b1;
    tick(8);
    chk("t2_partial_level", 32'(lvl), 32'd0);
    frame_byte(8'h3C);
    chk("t2_level", 32'(lvl), 32'd1);
    chk("t2_head", 32'(feat), 32'h3C);

    // Table: pushes interleaved with pops, including pops on empty
    do_reset();
    for (int k = 0; k < 8; k++) begin
      frame_byte(tbl[k].tx);
      for (int unsigned p = 0; p < tbl[k].pops; p++) pop1();
      chk("tbl_valid", 32'(valid), 32'(tbl[k].exp_valid));
      chk("tbl_level", 32'(lvl), 32'(tbl[k].exp_level));
      if (tbl[k].exp_valid) chk("tbl_head", 32'(feat), 32'(tbl[k].exp_head));
    end

    // Push and pop in the same cycle while full
    do_reset();
    for (int i = 0; i < 16; i++) frame_byte(8'(i));
    chk("full_level", 32'(lvl), 32'd16);
    d = 8'hAA;
    cs_n = 1'b0;
    tick(4);
    for (int i = 7; i >= 1; i--) spi_bit(d[i], m);
    mosi = d[0];
    tick(4);
    sclk = 1'b1;
    tick(3);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    chk("pushpop_full_level", 32'(lvl), 32'd16);
    chk("pushpop_full_ovf", 32'(ovf), 32'd0);
    chk("pushpop_full_head", 32'(feat), 32'h01);
    tick(3);
    sclk = 1'b0;
    tick(4);
    cs_n = 1'b1;
    tick(8);
    for (int i = 0; i < 15; i++) pop1();
    chk("pushpop_wrap_head", 32'(feat), 32'hAA);
    chk("pushpop_wrap_level", 32'(lvl), 32'd1);

    // Overflow: 18 bytes into 16 entries
    do_reset();
    for (int i = 0; i < 18; i++) frame_byte(8'(i));
    chk("t3_level", 32'(lvl), 32'd16);
    chk("t3_overflow", 32'(ovf), 32'd1);
    for (int i = 0; i < 13; i++) begin
      chk("t3_pop_order", 32'(feat), 32'(i));
      pop1();
    end
    chk("t3_level3", 32'(lvl), 32'd3);

    // Status readback: overflow=1, level=3, no frame_done since the last CS fall
    cs_n = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(1'b0, m);
      chk("t6_miso_bit", 32'(m), 32'(exp_st[i]));
    end
    tick(4);
    cs_n = 1'b1;
    tick(8);
    chk("t6_miso_idle", 32'(miso), 32'd0);
    chk("t6_level", 32'(lvl), 32'd4);
    for (int i = 13; i < 17; i++) begin
      chk("t3_pop_tail", 32'(feat), (i == 16) ? 32'h00 : 32'(i));
      pop1();
    end

    // Reset mid-byte, then a fresh frame
    cs_n = 1'b0;
    tick(4);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, m);
    rst_n = 1'b0;
    tick(2);
    cs_n = 1'b1;
    sclk = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    chk("t5_ovf_cleared", 32'(ovf), 32'd0);
    chk("t5_level_cleared", 32'(lvl), 32'd0);
    base = fd_count;
    frame_byte(8'h81);
    chk("t5_level", 32'(lvl), 32'd1);
    chk("t5_head", 32'(feat), 32'h81);
    chk("t5_frame_b1", 32'(fd_count - base), 32'd0);
    frame_byte(8'h02);
    frame_byte(8'h03);
    chk("t5_frame_b3", 32'(fd_count - base), 32'd0);
    frame_byte(8'h04);
    chk("t5_frame_b4", 32'(fd_count - base), 32'd1);

    // Nine bytes in one CS window with continuous popping
    do_reset();
    rd_en = 1'b1;
    base = fd_count;
    cs_n = 1'b0;
    tick(4);
    for (int k = 1; k <= 9; k++) begin
      send_byte(8'(k));
      tick(2);
      chk("t4_frame_pulses", 32'(fd_count - base), (k >= 8) ? 32'd2 : (k >= 4) ? 32'd1 : 32'd0);
    end
    tick(4);
    cs_n = 1'b1;
    rd_en = 1'b0;
    tick(8);
    chk("t4_level", 32'(lvl), 32'd0);
    chk("frame_done_width", 32'(long_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
